spi_display_tx: RTL and testbench
=================================

# spi_display_tx

Parametrised SPI transmit engine for the OLED display path. It sits between the frame/command logic and the panel pins. Words tagged with a data/command bit are buffered in an internal FIFO and serialised MSB-first. The SPI clock rate, clock mode, word width and FIFO depth are configurable. Chip-select is framed automatically around bursts, with a guaranteed idle gap between bursts.

## Interface
- DATA_W, 8: bits per SPI word (≥2)
- DEPTH, 4: FIFO entries (power of 2, ≥2)
- CLK_DIV, 2: clk cycles per SPI half-period (≥1)
- CPOL, 0: spi_clk idle level
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge
- CS_GAP, 2: minimum clk cycles cs_n held high between bursts (≥1)

Ports:
- clk  in  1  system clock (8.33 MHz PLL output)
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- in_data  in  DATA_W  word to send
- in_dc  in  1  D/C tag for the word (1 = data, 0 = command)
- in_valid  in  1  word offered
- in_ready  out  1  FIFO can accept; a transfer happens when in_valid&in_ready at a clk edge
- spi_clk  out  1  serial clock
- mosi  out  1  serial data
- dc  out  1  D/C line, aligned to the word being shifted
- cs_n  out  1  chip select, active low
- busy  out  1  FIFO non-empty or FSM not IDLE
- level  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- FIFO: registered occupancy, {dc,data} entries.
  - in_ready = !rst && (level != DEPTH), evaluated from the registered level.
  - Pop happens on the FSM's LOAD cycle.
  - Push and pop in the same cycle: level unchanged, order preserved.
  - When full, in_ready stays 0 until the cycle after a pop.
- FSM states: IDLE, LOAD, SETUP, SHIFT, HOLD, GAP.
  - IDLE → LOAD when level != 0.
  - LOAD (1 cycle): pop the head entry into the shift register and dc register. Then go to SETUP.
  - SETUP (one half-period):
    - cs_n = 0, dc = tag, spi_clk = CPOL.
    - CPHA=0: mosi = MSB.
    - CPHA=1: mosi holds its previous value until the first edge.
  - SHIFT: 2·DATA_W half-periods. spi_clk toggles at the end of SETUP and at the end of each half-period except the last one.
    - CPHA=0: mosi advances on each trailing edge.
    - CPHA=1: mosi advances on each leading edge, starting from MSB at the first leading edge.
    - After the final edge, spi_clk = CPOL.
  - HOLD (one half-period, cs_n low):
    - If level != 0, pop the next word at the end of HOLD and go to SETUP. cs_n stays low and there is no GAP.
    - Otherwise go to GAP.
  - GAP: cs_n = 1 for CS_GAP cycles, then IDLE.
- Half-period counter: counts 0..CLK_DIV-1. A half-period ends when it wraps.
- dc changes only at a SETUP entry, never inside SHIFT.

## Timing
- Reset values (asynchronous):
  - spi_clk = CPOL, mosi = 0, dc = 0, cs_n = 1, busy = 0, level = 0, in_ready = 0 while rst is high.
  - FSM is in IDLE; FIFO and any partial word are discarded.
- Reset mid-word: outputs return to reset values immediately. The word is not resumed.
- First-word latency: push accepted at edge t → LOAD at t+1 → cs_n low and SETUP from edge t+2.
- Single word: cs_n low for (2·DATA_W+2)·CLK_DIV cycles, then high for ≥CS_GAP cycles.
- Back-to-back words, FIFO never empty: word start spacing is (2·DATA_W+1)·CLK_DIV + 1 cycles. The +1 is the LOAD cycle, which occupies the tail of HOLD. cs_n remains continuously low.
- A push that arrives during HOLD and is accepted at least one cycle before HOLD ends joins the same burst. Otherwise it starts a new burst after GAP.
- busy is high from the cycle after the first accepted push until the last GAP cycle completes.

## Test plan
- Mode 0, CLK_DIV=2, push 0xA5 with dc=1 at edge t:
  - cs_n falls at t+2.
  - 8 rising edges sample mosi = 1,0,1,0,0,1,0,1; dc = 1 throughout.
  - cs_n rises at t+2+36 and stays high ≥2 cycles.
- Burst of 3 words (0x00 dc=0, 0xFF dc=1, 0x3C dc=1):
  - cs_n stays low across all three words.
  - Word starts are 35 cycles apart.
  - dc changes 0→1 only at the second SETUP.
  - 24 bits are received correctly.
- DEPTH=4, 6 consecutive pushes with in_valid held high:
  - in_ready drops when level = 4 and rises one cycle after each pop.
  - All 6 words are sent in order, with no loss or duplication.
- CPOL=1, CPHA=1, CLK_DIV=1, word 0x81:
  - spi_clk idles high.
  - mosi changes only on falling edges; rising edges sample 1,0,0,0,0,0,0,1.
- rst pulsed during bit 4 of a word with 2 words queued:
  - cs_n = 1, spi_clk = CPOL, level = 0 in the same cycle.
  - After release, nothing is sent until a new push.
- DATA_W=9 (DC-in-word mode):
  - Push 0x1AB → 9 bits 1,1,0,1,0,1,0,1,1 are sampled.
  - Single-word cs_n low time is 20·CLK_DIV cycles.

Source files
------------

// File: rtl/spi_display_tx.sv
// SPI transmit engine for the OLED display path: a {dc,data} FIFO feeding an
// MSB-first serialiser with automatic chip-select framing and an inter-burst gap.
module spi_display_tx #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0,
  parameter int CS_GAP  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_dc,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       spi_clk,
  output logic                       mosi,
  output logic                       dc,
  output logic                       cs_n,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int LW      = $clog2(DEPTH+1);
  localparam int PW      = $clog2(DEPTH);
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX+1);
  localparam int HW      = $clog2(2*DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t            r_state;
  logic [DATA_W:0]   r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic [HW-1:0]     r_half;
  logic              r_spi_clk;
  logic              r_mosi;
  logic              r_dc;
  logic              r_cs_n;

  logic              w_push;
  logic              w_pop;
  logic              w_nempty;
  logic              w_hp_end;
  logic              w_shift_edge;
  logic [DATA_W:0]   w_head;

  assign w_nempty     = (r_level != '0);
  assign in_ready     = !rst && (r_level != LW'(DEPTH));
  assign w_push       = in_valid && in_ready;
  assign w_pop        = (r_state == S_LOAD) || ((r_state == S_HOLD) && w_nempty);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_hp_end     = (r_cnt == CW'(CLK_DIV-1));
  // SHIFT half-period h ends on a trailing edge when h is even, leading when odd
  assign w_shift_edge = (r_half[0] == CPHA);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_dc, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_half    <= '0;
      r_shift   <= '0;
      r_spi_clk <= CPOL;
      r_mosi    <= 1'b0;
      r_dc      <= 1'b0;
      r_cs_n    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (w_nempty) r_state <= S_LOAD;
        S_LOAD: begin
          r_state <= S_SETUP;
          r_cnt   <= '0;
        end
        S_SETUP: begin
          if (w_hp_end) begin
            r_cnt     <= '0;
            r_half    <= '0;
            r_spi_clk <= ~r_spi_clk;
            r_state   <= S_SHIFT;
            if (CPHA) begin
              r_mosi  <= r_shift[DATA_W-1];
              r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_SHIFT: begin
          if (w_hp_end) begin
            r_cnt <= '0;
            if (r_half == HW'(2*DATA_W-1)) begin
              r_state <= S_HOLD;
            end else begin
              r_half    <= r_half + HW'(1);
              r_spi_clk <= ~r_spi_clk;
              if (w_shift_edge) begin
                r_mosi  <= r_shift[DATA_W-1];
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
              end
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // a queued word cuts HOLD short: its pop cycle is the LOAD of the next word
        S_HOLD: begin
          if (w_nempty) begin
            r_state <= S_SETUP;
            r_cnt   <= '0;
          end else if (w_hp_end) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == CW'(CS_GAP-1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_pop) begin
        r_dc      <= w_head[DATA_W];
        r_cs_n    <= 1'b0;
        r_spi_clk <= CPOL;
        if (CPHA) begin
          r_shift <= w_head[DATA_W-1:0];
        end else begin
          r_mosi  <= w_head[DATA_W-1];
          r_shift <= {w_head[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign spi_clk = r_spi_clk;
  assign mosi    = r_mosi;
  assign dc      = r_dc;
  assign cs_n    = r_cs_n;
  assign busy    = w_nempty || (r_state != S_IDLE);
  assign level   = r_level;

endmodule

// File: tb/tb_spi_display_tx.sv
// Bench for spi_display_tx: three configurations driven by directed and random
// pushes; a pin-level SPI receiver rebuilds words and timestamps the framing.
module tb_spi_display_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] vld = '0;
  logic [2:0] dcin = '0;
  logic [7:0] dat0 = '0;
  logic [7:0] dat1 = '0;
  logic [8:0] dat2 = '0;
  logic [2:0] rdy, sclk, mosi, dco, csn, bsy;
  logic [2:0] lvl0;
  logic [1:0] lvl1;
  logic [2:0] lvl2;

  always #5 clk = ~clk;

  spi_display_tx #(.DATA_W(8), .DEPTH(4), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .CS_GAP(2)) dut0 (
    .clk(clk), .rst(rst), .in_data(dat0), .in_dc(dcin[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .spi_clk(sclk[0]), .mosi(mosi[0]), .dc(dco[0]), .cs_n(csn[0]), .busy(bsy[0]), .level(lvl0));

  spi_display_tx #(.DATA_W(8), .DEPTH(2), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1), .CS_GAP(2)) dut1 (
    .clk(clk), .rst(rst), .in_data(dat1), .in_dc(dcin[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .spi_clk(sclk[1]), .mosi(mosi[1]), .dc(dco[1]), .cs_n(csn[1]), .busy(bsy[1]), .level(lvl1));

  spi_display_tx #(.DATA_W(9), .DEPTH(4), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .CS_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(dat2), .in_dc(dcin[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .spi_clk(sclk[2]), .mosi(mosi[2]), .dc(dco[2]), .cs_n(csn[2]), .busy(bsy[2]), .level(lvl2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bitcnt [3];
  int acc [3];
  int wdc [3];
  int dwv [3] = '{8, 8, 9};
  logic [2:0] p_sclk, p_mosi, p_dc, p_csn, p_bsy;
  int mosi_bad = 0;
  int dc_bad = 0;
  int busy_fall = -1;
  int fall_q [$];
  int rise_q [$];
  int edge_q [$];
  int rx_q [$];
  int exp_q [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // receiver: samples on rising spi_clk while cs_n is low (modes 0 and 3)
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        bitcnt[i] = 0;
        acc[i] = 0;
      end else begin
        if (csn[i] !== p_csn[i]) begin
          if (csn[i] == 1'b0) fall_q.push_back(cyc);
          else rise_q.push_back(cyc);
        end
        if (p_bsy[i] && !bsy[i]) busy_fall = cyc;
        if (mosi[i] !== p_mosi[i]) begin
          if (!p_sclk[i] && sclk[i]) mosi_bad++;
          if (i == 1 && !csn[i] && !(p_sclk[i] && !sclk[i])) mosi_bad++;
        end
        if (dco[i] !== p_dc[i] && bitcnt[i] != 0) dc_bad++;
        if (!p_sclk[i] && sclk[i] && !csn[i]) begin
          if (bitcnt[i] == 0) begin
            edge_q.push_back(cyc);
            wdc[i] = int'(dco[i]);
          end else if (int'(dco[i]) != wdc[i]) begin
            dc_bad++;
          end
          acc[i] = (acc[i] << 1) | int'(mosi[i]);
          bitcnt[i]++;
          if (bitcnt[i] == dwv[i]) begin
            rx_q.push_back((wdc[i] << 16) | acc[i]);
            bitcnt[i] = 0;
            acc[i] = 0;
          end
        end
      end
      p_sclk[i] = sclk[i];
      p_mosi[i] = mosi[i];
      p_dc[i]   = dco[i];
      p_csn[i]  = csn[i];
      p_bsy[i]  = bsy[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fq(input int i);
    return (i < fall_q.size()) ? fall_q[i] : -1;
  endfunction

  function automatic int rq(input int i);
    return (i < rise_q.size()) ? rise_q[i] : -1;
  endfunction

  function automatic int eq(input int i);
    return (i < edge_q.size()) ? edge_q[i] : -1;
  endfunction

  task automatic clearq();
    fall_q.delete();
    rise_q.delete();
    edge_q.delete();
    rx_q.delete();
    exp_q.delete();
    mosi_bad = 0;
    dc_bad = 0;
    busy_fall = -1;
  endtask

  task automatic push(input int id, input int d, input logic c, output int t);
    int n;
    n = 0;
    case (id)
      0: dat0 = 8'(d);
      1: dat1 = 8'(d);
      default: dat2 = 9'(d);
    endcase
    dcin[id] = c;
    vld[id] = 1'b1;
    while (rdy[id] !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk("push_accept_timeout", int'(n < 500), 1);
    tick();
    t = cyc;
    vld[id] = 1'b0;
    exp_q.push_back((int'(c) << 16) | d);
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    tick();
    while (bsy[id] !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(n < 3000), 1);
    repeat (6) tick();
  endtask

  task automatic compare_rx(input string tag);
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({tag, "_word"}, rx_q[i], exp_q[i]);
  endtask

  initial begin
    int t, n, idx, maxl, rdy_bad;
    logic acc_now;
    int wd [6];
    int wc [6];

    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_cs_n", int'(csn[i]), 1);
      chk("rst_sclk", int'(sclk[i]), int'(i == 1));
      chk("rst_mosi", int'(mosi[i]), 0);
      chk("rst_dc", int'(dco[i]), 0);
      chk("rst_busy", int'(bsy[i]), 0);
      chk("rst_ready", int'(rdy[i]), 0);
    end
    chk("rst_level0", int'(lvl0), 0);
    chk("rst_level1", int'(lvl1), 0);
    chk("rst_level2", int'(lvl2), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", int'(rdy), 7);

    // single word, mode 0, CLK_DIV=2
    clearq();
    chk("b_busy_before", int'(bsy[0]), 0);
    push(0, 'hA5, 1'b1, t);
    chk("b_busy_after_push", int'(bsy[0]), 1);
    chk("b_level_after_push", int'(lvl0), 1);
    wait_idle(0);
    chk("b_fall_count", fall_q.size(), 1);
    chk("b_cs_fall", fq(0), t + 2);
    chk("b_cs_rise", rq(0), t + 2 + (2*8+2)*2);
    chk("b_busy_fall", busy_fall, t + 2 + 36 + 2);
    compare_rx("b_rx");
    chk("b_dc_bad", dc_bad, 0);
    chk("b_mosi_bad", mosi_bad, 0);

    // three-word burst
    clearq();
    push(0, 'h00, 1'b0, t);
    push(0, 'hFF, 1'b1, n);
    push(0, 'h3C, 1'b1, n);
    wait_idle(0);
    chk("c_fall_count", fall_q.size(), 1);
    chk("c_rise_count", rise_q.size(), 1);
    chk("c_space1", eq(1) - eq(0), 35);
    chk("c_space2", eq(2) - eq(1), 35);
    chk("c_cs_low", rq(0) - fq(0), 2*35 + 36);
    compare_rx("c_rx");
    chk("c_dc_bad", dc_bad, 0);

    // six random words with in_valid held high through FIFO-full
    clearq();
    for (int i = 0; i < 6; i++) begin
      wd[i] = int'($urandom_range(0, 255));
      wc[i] = int'($urandom_range(0, 1));
    end
    idx = 0; n = 0; maxl = 0; rdy_bad = 0;
    dat0 = 8'(wd[0]);
    dcin[0] = wc[0][0];
    vld[0] = 1'b1;
    while (idx < 6 && n < 1000) begin
      if (rdy[0] !== (lvl0 != 3'd4)) rdy_bad++;
      if (int'(lvl0) > maxl) maxl = int'(lvl0);
      acc_now = rdy[0];
      tick();
      n++;
      if (acc_now) begin
        exp_q.push_back((wc[idx] << 16) | wd[idx]);
        idx++;
        if (idx < 6) begin
          dat0 = 8'(wd[idx]);
          dcin[0] = wc[idx][0];
        end
      end
    end
    vld[0] = 1'b0;
    chk("d_push_done", idx, 6);
    wait_idle(0);
    chk("d_max_level", maxl, 4);
    chk("d_ready_vs_level", rdy_bad, 0);
    chk("d_fall_count", fall_q.size(), 1);
    chk("d_rise_count", rise_q.size(), 1);
    for (int i = 1; i < 6; i++) chk("d_space", eq(i) - eq(i-1), 35);
    compare_rx("d_rx");

    // CPOL=1 CPHA=1 CLK_DIV=1
    clearq();
    chk("e_sclk_idle", int'(sclk[1]), 1);
    push(1, 'h81, 1'($urandom_range(0, 1)), t);
    wait_idle(1);
    chk("e_cs_fall", fq(0), t + 2);
    chk("e_cs_low", rq(0) - fq(0), 18);
    chk("e_sclk_idle_after", int'(sclk[1]), 1);
    compare_rx("e_rx");
    chk("e_mosi_edges", mosi_bad, 0);
    clearq();
    push(1, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), t);
    push(1, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), t);
    wait_idle(1);
    chk("e_burst_fall_count", fall_q.size(), 1);
    chk("e_burst_space", eq(1) - eq(0), 18);
    compare_rx("e_burst_rx");
    chk("e_burst_mosi_edges", mosi_bad, 0);

    // reset during bit 4 with two words queued
    clearq();
    for (int i = 0; i < 3; i++) push(0, int'($urandom_range(0, 255)), 1'b1, t);
    n = 0;
    while (bitcnt[0] != 4 && n < 200) begin
      tick();
      n++;
    end
    chk("f_reach_bit4", int'(n < 200), 1);
    chk("f_level_before", int'(lvl0), 2);
    rst = 1'b1;
    #1;
    chk("f_rst_cs_n", int'(csn[0]), 1);
    chk("f_rst_sclk", int'(sclk[0]), 0);
    chk("f_rst_level", int'(lvl0), 0);
    chk("f_rst_ready", int'(rdy[0]), 0);
    chk("f_rst_busy", int'(bsy[0]), 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    repeat (120) tick();
    chk("f_no_restart", fall_q.size(), 1);
    chk("f_no_rx", rx_q.size(), 0);
    chk("f_idle_cs_n", int'(csn[0]), 1);
    push(0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), t);
    wait_idle(0);
    compare_rx("f_rx_after");

    // DATA_W=9
    clearq();
    push(2, 'h1AB, 1'($urandom_range(0, 1)), t);
    wait_idle(2);
    chk("g_cs_fall", fq(0), t + 2);
    chk("g_cs_low", rq(0) - fq(0), 40);
    compare_rx("g_rx");
    clearq();
    push(2, int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), t);
    push(2, int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), t);
    wait_idle(2);
    chk("g_burst_fall_count", fall_q.size(), 1);
    chk("g_burst_space", eq(1) - eq(0), 39);
    compare_rx("g_burst_rx");
    chk("g_dc_bad", dc_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
